// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-side branch predictor: BHT counter encoding,
// default table geometry and the BTB entry layout.
// Ports: none (package only).
package branch_predictor_pkg;

  localparam int BHT_IDX_BITS_DEF = 7;
  localparam int BTB_IDX_BITS_DEF = 5;
  localparam int GHR_BITS_DEF     = 7;
  localparam int BTB_TAG_BITS_DEF = 32 - BTB_IDX_BITS_DEF - 2;

  // 2-bit saturating direction counter; MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_t;

  typedef struct packed {
    logic                        valid;
    logic [BTB_TAG_BITS_DEF-1:0] tag;
    logic [31:0]                 target;
  } btb_entry_t;

  function automatic logic ctr_predicts_taken(input bht_ctr_t c);
    return c[1];
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of one 2-bit saturating direction counter.
// Latency: combinational.  Ports: ctr_i current state, taken_i resolved
// direction, ctr_o next state (saturates at SNT and ST).
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  bht_ctr_t ctr_i,
  input  logic     taken_i,
  output bht_ctr_t ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    case (ctr_i)
      SNT:     ctr_o = taken_i ? WNT : SNT;
      WNT:     ctr_o = taken_i ? WT  : SNT;
      WT:      ctr_o = taken_i ? ST  : WNT;
      ST:      ctr_o = taken_i ? ST  : WT;
      default: ctr_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side direction/target predictor: 2-bit BHT + direct-mapped BTB,
// prediction registered one cycle after lookup, trained from EX resolution.
// Ports: clk/rst (async active-low); pred_req/pred_pc/stall/flush in,
// pred_valid/pred_taken/pred_target/pred_idx out; upd_* training from EX.
// Build option BRANCH_PRED_GSHARE_EN: gshare indexing with a global history
// register; when undefined the predictor is bimodal and no GHR exists.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BHT_IDX_BITS = BHT_IDX_BITS_DEF,
  parameter int BTB_IDX_BITS = BTB_IDX_BITS_DEF
`ifdef BRANCH_PRED_GSHARE_EN
  , parameter int GHR_BITS = GHR_BITS_DEF
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pred_req,
  input  logic [31:0]             pred_pc,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    pred_valid,
  output logic                    pred_taken,
  output logic [31:0]             pred_target,
  output logic [BHT_IDX_BITS-1:0] pred_idx,
  input  logic                    upd_valid,
  input  logic [31:0]             upd_pc,
  input  logic [BHT_IDX_BITS-1:0] upd_idx,
  input  logic                    upd_taken,
  input  logic [31:0]             upd_target
);

  localparam int BHT_ENTRIES = 1 << BHT_IDX_BITS;
  localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
  localparam int TAG_BITS    = 30 - BTB_IDX_BITS;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [31:0]         target;
  } btb_ent_t;

  bht_ctr_t bht_q [BHT_ENTRIES];
  btb_ent_t btb_q [BTB_ENTRIES];

  // ---------------- lookup (reads pre-update table contents) ----------------
  logic [BHT_IDX_BITS-1:0] lk_bht_idx;
  logic [BTB_IDX_BITS-1:0] lk_btb_idx;
  logic [TAG_BITS-1:0]     lk_tag;
  btb_ent_t                lk_btb;
  logic                    lk_hit;
  logic                    lk_taken;
  logic [31:0]             lk_target;

`ifdef BRANCH_PRED_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q;

  assign lk_bht_idx = pred_pc[BHT_IDX_BITS+1:2] ^ BHT_IDX_BITS'(ghr_q);

  // History is only advanced by resolved branches, so it never needs repair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q <= '0;
    end else if (upd_valid) begin
      ghr_q <= {ghr_q[GHR_BITS-2:0], upd_taken};
    end
  end
`else
  assign lk_bht_idx = pred_pc[BHT_IDX_BITS+1:2];
`endif

  assign lk_btb_idx = pred_pc[BTB_IDX_BITS+1:2];
  assign lk_tag     = pred_pc[31:BTB_IDX_BITS+2];
  assign lk_btb     = btb_q[lk_btb_idx];
  assign lk_hit     = lk_btb.valid && (lk_btb.tag == lk_tag);
  assign lk_taken   = lk_hit && ctr_predicts_taken(bht_q[lk_bht_idx]);
  assign lk_target  = lk_taken ? lk_btb.target : (pred_pc + 32'd4);

  // ---------------- registered prediction ----------------
  logic                    pred_valid_q, pred_valid_d;
  logic                    pred_taken_q, pred_taken_d;
  logic [31:0]             pred_target_q, pred_target_d;
  logic [BHT_IDX_BITS-1:0] pred_idx_q, pred_idx_d;

  // Flush only kills validity; the payload simply holds.
  always_comb begin
    pred_valid_d  = pred_valid_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    pred_idx_d    = pred_idx_q;
    if (flush) begin
      pred_valid_d = 1'b0;
    end else if (!stall) begin
      pred_valid_d  = pred_req;
      pred_taken_d  = lk_taken;
      pred_target_d = lk_target;
      pred_idx_d    = lk_bht_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      pred_idx_q    <= '0;
    end else begin
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      pred_idx_q    <= pred_idx_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign pred_idx    = pred_idx_q;

  // ---------------- training ----------------
  bht_ctr_t upd_ctr_d;

  sat_counter2 u_sat_counter2 (
    .ctr_i   (bht_q[upd_idx]),
    .taken_i (upd_taken),
    .ctr_o   (upd_ctr_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= WNT;
      end
    end else if (upd_valid) begin
      bht_q[upd_idx] <= upd_ctr_d;
    end
  end

  logic [BTB_IDX_BITS-1:0] upd_btb_idx;
  btb_ent_t                upd_btb_d;

  assign upd_btb_idx      = upd_pc[BTB_IDX_BITS+1:2];
  assign upd_btb_d.valid  = 1'b1;
  assign upd_btb_d.tag    = upd_pc[31:BTB_IDX_BITS+2];
  assign upd_btb_d.target = upd_target;

  // Only taken branches allocate; a later taken branch aliasing the same
  // slot simply replaces the entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i] <= '0;
      end
    end else if (upd_valid && upd_taken) begin
      btb_q[upd_btb_idx] <= upd_btb_d;
    end
  end

  // Byte-offset bits of word-aligned PCs carry no information here.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pred_pc[1:0], upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic        stall;
  logic        flush;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [6:0]  pred_idx;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [6:0]  upd_idx;
  logic        upd_taken;
  logic [31:0] upd_target;

  int checks = 0;
  int errors = 0;

  branch_predictor dut (
    .clk         (clk),
    .rst         (rst_n),
    .pred_req    (pred_req),
    .pred_pc     (pred_pc),
    .stall       (stall),
    .flush       (flush),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .pred_idx    (pred_idx),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_idx     (upd_idx),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        chk_all;   // 0: only pred_valid is defined after a flush
    logic        ev;
    logic        et;
    logic [31:0] etgt;
    logic [6:0]  eidx;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic req, input logic [31:0] pc,
                              input logic st, input logic fl,
                              input logic uv, input logic [31:0] upc,
                              input logic ut, input logic [31:0] utgt,
                              input logic all, input logic ev, input logic et,
                              input logic [31:0] etgt, input logic [6:0] eidx);
    vec_t v;
    v.req = req; v.pc = pc; v.stall = st; v.flush = fl;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.chk_all = all; v.ev = ev; v.et = et; v.etgt = etgt; v.eidx = eidx;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic all, input logic ev,
                         input logic et, input logic [31:0] etgt, input logic [6:0] eidx);
    chk({nm, "_valid"}, 32'(pred_valid), 32'(ev));
    if (all) begin
      chk({nm, "_taken"},  32'(pred_taken), 32'(et));
      chk({nm, "_target"}, pred_target, etgt);
      chk({nm, "_idx"},    32'(pred_idx), 32'(eidx));
    end
  endtask

  task automatic drive(input vec_t v);
    logic [31:0] tmp;
    pred_req   = v.req;
    pred_pc    = v.pc;
    stall      = v.stall;
    flush      = v.flush;
    upd_valid  = v.uv;
    upd_pc     = v.upc;
    tmp        = v.upc;
    upd_idx    = tmp[8:2];   // bimodal build: the pipe carries PC bits
    upd_taken  = v.ut;
    upd_target = v.utgt;
  endtask

  initial begin
    vec_t idle;
    // Branch at 0x60 (BHT 0x18, BTB slot 0x18) -> 0x40;
    // branch at 0x100 (BHT 0x40, BTB slot 0) -> 0x200.
    //               req pc            st fl uv upc       ut utgt      all ev et etgt          eidx
    vt.push_back(mk(1, 32'h60,       0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 0, 32'h64,       7'h18)); // 0 cold
    vt.push_back(mk(1, 32'h60,       0, 0, 1, 32'h60,  1, 32'h40,  1, 1, 0, 32'h64,       7'h18)); // 1 ctr01 miss
    vt.push_back(mk(1, 32'h60,       0, 0, 1, 32'h60,  1, 32'h40,  1, 1, 1, 32'h40,       7'h18)); // 2 ctr10 hit
    vt.push_back(mk(1, 32'h60,       0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h40,       7'h18)); // 3 ctr11
    vt.push_back(mk(1, 32'h100,      0, 0, 1, 32'h100, 1, 32'h200, 1, 1, 0, 32'h104,      7'h40)); // 4 01->10
    vt.push_back(mk(1, 32'h100,      0, 0, 1, 32'h100, 1, 32'h200, 1, 1, 1, 32'h200,      7'h40)); // 5 10->11
    vt.push_back(mk(1, 32'h100,      0, 0, 1, 32'h100, 1, 32'h200, 1, 1, 1, 32'h200,      7'h40)); // 6 11->11
    vt.push_back(mk(1, 32'h100,      0, 0, 1, 32'h100, 1, 32'h200, 1, 1, 1, 32'h200,      7'h40)); // 7 11->11
    vt.push_back(mk(1, 32'h100,      0, 0, 1, 32'h100, 0, 32'h0,   1, 1, 1, 32'h200,      7'h40)); // 8 11->10
    vt.push_back(mk(1, 32'h100,      0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h200,      7'h40)); // 9 10 still taken
    vt.push_back(mk(1, 32'h100,      0, 0, 1, 32'h100, 0, 32'h0,   1, 1, 1, 32'h200,      7'h40)); // 10 10->01
    vt.push_back(mk(1, 32'h100,      0, 0, 1, 32'h100, 0, 32'h0,   1, 1, 0, 32'h104,      7'h40)); // 11 01->00
    vt.push_back(mk(1, 32'h100,      0, 0, 1, 32'h100, 0, 32'h0,   1, 1, 0, 32'h104,      7'h40)); // 12 00->00
    vt.push_back(mk(1, 32'h100,      0, 0, 1, 32'h100, 1, 32'h200, 1, 1, 0, 32'h104,      7'h40)); // 13 00->01
    vt.push_back(mk(1, 32'h100,      0, 0, 1, 32'h100, 1, 32'h200, 1, 1, 0, 32'h104,      7'h40)); // 14 same-cycle rd/wr 01->10
    vt.push_back(mk(1, 32'h100,      0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h200,      7'h40)); // 15 sees 10
    vt.push_back(mk(0, 32'h100,      0, 0, 0, 32'h0,   0, 32'h0,   1, 0, 1, 32'h200,      7'h40)); // 16 no req
    vt.push_back(mk(1, 32'hFFFFFFFC, 0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 0, 32'h0,        7'h7F)); // 17 pc+4 wraps
    vt.push_back(mk(1, 32'h300,      0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 0, 32'h304,      7'h40)); // 18 tag mismatch
    vt.push_back(mk(1, 32'h60,       1, 0, 0, 32'h0,   0, 32'h0,   1, 1, 0, 32'h304,      7'h40)); // 19 stall
    vt.push_back(mk(0, 32'h100,      1, 0, 1, 32'h100, 0, 32'h0,   1, 1, 0, 32'h304,      7'h40)); // 20 stall + train 10->01
    vt.push_back(mk(1, 32'hFFFFFFFC, 1, 0, 0, 32'h0,   0, 32'h0,   1, 1, 0, 32'h304,      7'h40)); // 21 stall
    vt.push_back(mk(1, 32'h60,       1, 1, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,        7'h0));  // 22 flush beats stall
    vt.push_back(mk(1, 32'h60,       0, 1, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,        7'h0));  // 23 flush
    vt.push_back(mk(1, 32'h60,       0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h40,       7'h18)); // 24 trained 0x60
    vt.push_back(mk(1, 32'h100,      0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 0, 32'h104,      7'h40)); // 25 update under stall landed

    idle = mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0, 7'h0);
    drive(idle);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 1'b1, 1'b0, 1'b0, 32'h0, 7'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", i), vt[i].chk_all, vt[i].ev, vt[i].et, vt[i].etgt, vt[i].eidx);
    end

    // Asynchronous reset landing in the middle of a taken update to 0x60.
    drive(mk(1, 32'h60, 0, 0, 1, 32'h60, 1, 32'h40, 1, 0, 0, 32'h0, 7'h0));
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b1, 1'b0, 1'b0, 32'h0, 7'h0);
    @(posedge clk);
    #1;
    drive(idle);
    rst_n = 1'b1;

    drive(mk(1, 32'h60, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0, 7'h0));
    @(posedge clk);
    #1;
    chk_out("post_rst_60", 1'b1, 1'b1, 1'b0, 32'h64, 7'h18);

    drive(mk(1, 32'h1F0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0, 7'h0));
    @(posedge clk);
    #1;
    chk_out("post_rst_1f0", 1'b1, 1'b1, 1'b0, 32'h1F4, 7'h7C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
